// File: rtl/ps2_pkg.sv
// rtl/ps2_pkg.sv - shared PS/2 constants, frame states and key-table entry type
package ps2_pkg;

    localparam logic [7:0] PS2_BREAK = 8'hF0;
    localparam logic [7:0] PS2_EXT   = 8'hE0;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DATA   = 2'd1,
        ST_PARITY = 2'd2,
        ST_STOP   = 2'd3
    } frame_state_t;

    typedef struct packed {
        logic       ext;
        logic [7:0] code;
    } key_entry_t;

endpackage

// File: rtl/ps2_frame_rx.sv
// rtl/ps2_frame_rx.sv - PS/2 frame deserialiser (sync, edge detect, FSM, timeout); PS2_PARITY_CHECK_EN enables odd-parity check
module ps2_frame_rx
    import ps2_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 100000
) (
    input  logic       sys_clk,
    input  logic       async_rst,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    output logic       byte_valid,
    output logic [7:0] data_byte,
    output logic       frame_err
);

    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    logic [1:0]   clk_sync;
    logic         clk_prev;
    logic [1:0]   data_sync;
    logic         fe;
    logic         data_bit;

    frame_state_t state, state_n;
    logic [2:0]   bit_cnt, bit_cnt_n;
    logic [7:0]   shift, shift_n;
    logic [TW-1:0] to_cnt, to_cnt_n;
    logic         parity_bad;

`ifdef PS2_PARITY_CHECK_EN
    logic         par_bit, par_bit_n;
    // Odd parity: data plus parity bit must contain an odd number of ones.
    assign parity_bad = ~(^{shift, par_bit});
`else
    assign parity_bad = 1'b0;
`endif

    assign fe       = clk_prev & ~clk_sync[1];
    assign data_bit = data_sync[1];
    assign data_byte = shift;

    // Two-flop synchronisers plus one extra clock flop for falling-edge detection.
    always_ff @(posedge sys_clk or posedge async_rst) begin
        if (async_rst) begin
            clk_sync  <= 2'b00;
            clk_prev  <= 1'b0;
            data_sync <= 2'b00;
        end else begin
            clk_sync  <= {clk_sync[0], ps2_clk};
            clk_prev  <= clk_sync[1];
            data_sync <= {data_sync[0], ps2_data};
        end
    end

    // Frame state register, bit counter, shifter and timeout counter.
    always_ff @(posedge sys_clk or posedge async_rst) begin
        if (async_rst) begin
            state   <= ST_IDLE;
            bit_cnt <= 3'd0;
            shift   <= 8'h00;
            to_cnt  <= '0;
`ifdef PS2_PARITY_CHECK_EN
            par_bit <= 1'b0;
`endif
        end else begin
            state   <= state_n;
            bit_cnt <= bit_cnt_n;
            shift   <= shift_n;
            to_cnt  <= to_cnt_n;
`ifdef PS2_PARITY_CHECK_EN
            par_bit <= par_bit_n;
`endif
        end
    end

    // Next-state logic: all frame work on fe; an fe in the timeout cycle takes priority.
    always_comb begin
        state_n    = state;
        bit_cnt_n  = bit_cnt;
        shift_n    = shift;
        to_cnt_n   = to_cnt;
        byte_valid = 1'b0;
        frame_err  = 1'b0;
`ifdef PS2_PARITY_CHECK_EN
        par_bit_n  = par_bit;
`endif
        if (fe) begin
            to_cnt_n = '0;
            case (state)
                ST_IDLE: begin
                    if (!data_bit) begin
                        state_n   = ST_DATA;
                        bit_cnt_n = 3'd0;
                    end else begin
                        frame_err = 1'b1;
                    end
                end
                ST_DATA: begin
                    shift_n   = {data_bit, shift[7:1]};
                    bit_cnt_n = bit_cnt + 3'd1;
                    if (bit_cnt == 3'd7) begin
                        state_n = ST_PARITY;
                    end
                end
                ST_PARITY: begin
`ifdef PS2_PARITY_CHECK_EN
                    par_bit_n = data_bit;
`endif
                    state_n = ST_STOP;
                end
                ST_STOP: begin
                    state_n = ST_IDLE;
                    if (!data_bit || parity_bad) begin
                        frame_err = 1'b1;
                    end else begin
                        byte_valid = 1'b1;
                    end
                end
                default: state_n = ST_IDLE;
            endcase
        end else if (state == ST_IDLE) begin
            to_cnt_n = '0;
        end else if (to_cnt == TW'(TIMEOUT_CYCLES)) begin
            state_n   = ST_IDLE;
            to_cnt_n  = '0;
            frame_err = 1'b1;
        end else begin
            to_cnt_n = to_cnt + TW'(1);
        end
    end

endmodule

// File: rtl/ps2_nkro_receiver.sv
// rtl/ps2_nkro_receiver.sv - PS/2 NKRO receiver top: prefix decoder and held-key table; PS2_PARITY_CHECK_EN passed to ps2_frame_rx
module ps2_nkro_receiver
    import ps2_pkg::*;
#(
    parameter int MAX_KEYS       = 4,
    parameter int TIMEOUT_CYCLES = 100000
) (
    input  logic                  sys_clk,
    input  logic                  async_rst,
    input  logic                  ps2_clk,
    input  logic                  ps2_data,
    output logic [MAX_KEYS*8-1:0] key_code,
    output logic [MAX_KEYS-1:0]   key_ext,
    output logic [MAX_KEYS-1:0]   key_valid,
    output logic                  event_valid,
    output logic [7:0]            event_code,
    output logic                  event_break,
    output logic                  event_ext,
    output logic                  overflow,
    output logic                  frame_err
);

    logic          rx_valid;
    logic [7:0]    rx_byte;
    logic          rx_err;

    logic          brk;
    logic          ext;
    key_entry_t    tbl [MAX_KEYS];
    logic [MAX_KEYS-1:0] valid;

    logic          is_event;
    key_entry_t    cur;
    logic [MAX_KEYS-1:0] hit_vec;
    logic [MAX_KEYS-1:0] free_oh;
    logic          any_hit;
    logic          any_free;

    ps2_frame_rx #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_rx (
        .sys_clk   (sys_clk),
        .async_rst (async_rst),
        .ps2_clk   (ps2_clk),
        .ps2_data  (ps2_data),
        .byte_valid(rx_valid),
        .data_byte (rx_byte),
        .frame_err (rx_err)
    );

    assign is_event = rx_valid && (rx_byte != PS2_BREAK) && (rx_byte != PS2_EXT);
    assign cur      = '{ext: ext, code: rx_byte};
    // Lowest clear bit of valid is the lowest-index free slot.
    assign free_oh  = ~valid & (valid + MAX_KEYS'(1));
    assign any_hit  = |hit_vec;
    assign any_free = |free_oh;

    // Full 9-bit {ext,code} match against occupied slots only.
    always_comb begin
        hit_vec = '0;
        for (int i = 0; i < MAX_KEYS; i++) begin
            hit_vec[i] = valid[i] && (tbl[i] == cur);
        end
    end

    // Flatten the table onto the output buses.
    always_comb begin
        key_code = '0;
        key_ext  = '0;
        for (int i = 0; i < MAX_KEYS; i++) begin
            key_code[8*i +: 8] = tbl[i].code;
            key_ext[i]         = tbl[i].ext;
        end
        key_valid = valid;
    end

    // Prefix decoder: F0/E0 set flags, any other byte emits an event and clears them.
    always_ff @(posedge sys_clk or posedge async_rst) begin
        if (async_rst) begin
            brk         <= 1'b0;
            ext         <= 1'b0;
            event_valid <= 1'b0;
            event_code  <= 8'h00;
            event_break <= 1'b0;
            event_ext   <= 1'b0;
            overflow    <= 1'b0;
            frame_err   <= 1'b0;
        end else begin
            event_valid <= 1'b0;
            overflow    <= 1'b0;
            frame_err   <= rx_err;
            if (rx_err) begin
                brk <= 1'b0;
                ext <= 1'b0;
            end else if (rx_valid) begin
                if (rx_byte == PS2_BREAK) begin
                    brk <= 1'b1;
                end else if (rx_byte == PS2_EXT) begin
                    ext <= 1'b1;
                end else begin
                    event_valid <= 1'b1;
                    event_code  <= rx_byte;
                    event_break <= brk;
                    event_ext   <= ext;
                    brk         <= 1'b0;
                    ext         <= 1'b0;
                    overflow    <= !brk && !any_hit && !any_free;
                end
            end
        end
    end

    // Key table: makes fill the lowest free slot, breaks clear only the valid bit.
    always_ff @(posedge sys_clk or posedge async_rst) begin
        if (async_rst) begin
            valid <= '0;
            for (int i = 0; i < MAX_KEYS; i++) begin
                tbl[i] <= '0;
            end
        end else if (is_event) begin
            for (int i = 0; i < MAX_KEYS; i++) begin
                if (!brk && !any_hit && free_oh[i]) begin
                    tbl[i]   <= cur;
                    valid[i] <= 1'b1;
                end
                if (brk && hit_vec[i]) begin
                    valid[i] <= 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_ps2_nkro_receiver.sv
// tb/tb_ps2_nkro_receiver.sv - directed self-checking bench for ps2_nkro_receiver
`timescale 1ns/1ps
module tb_ps2_nkro_receiver;

    localparam int MAX_KEYS = 4;
    localparam int TIMEOUT  = 200;

    logic                  sys_clk = 1'b0;
    logic                  async_rst = 1'b1;
    logic                  ps2_clk = 1'b1;
    logic                  ps2_data = 1'b1;
    logic [MAX_KEYS*8-1:0] key_code;
    logic [MAX_KEYS-1:0]   key_ext;
    logic [MAX_KEYS-1:0]   key_valid;
    logic                  event_valid;
    logic [7:0]            event_code;
    logic                  event_break;
    logic                  event_ext;
    logic                  overflow;
    logic                  frame_err;

    int vectors     = 0;
    int miscompares = 0;
    int ev_count    = 0;
    int ov_count    = 0;
    int err_count   = 0;
    int exp_ev      = 0;
    int exp_err     = 0;
    logic [7:0] last_code  = 8'h00;
    logic       last_break = 1'b0;
    logic       last_ext   = 1'b0;

    ps2_nkro_receiver #(
        .MAX_KEYS      (MAX_KEYS),
        .TIMEOUT_CYCLES(TIMEOUT)
    ) dut (
        .sys_clk    (sys_clk),
        .async_rst  (async_rst),
        .ps2_clk    (ps2_clk),
        .ps2_data   (ps2_data),
        .key_code   (key_code),
        .key_ext    (key_ext),
        .key_valid  (key_valid),
        .event_valid(event_valid),
        .event_code (event_code),
        .event_break(event_break),
        .event_ext  (event_ext),
        .overflow   (overflow),
        .frame_err  (frame_err)
    );

    always #5 sys_clk = ~sys_clk;

    // Pulse monitor on the inactive edge.
    always @(negedge sys_clk) begin
        if (event_valid) begin
            ev_count   = ev_count + 1;
            last_code  = event_code;
            last_break = event_break;
            last_ext   = event_ext;
        end
        if (overflow)  ov_count  = ov_count + 1;
        if (frame_err) err_count = err_count + 1;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic send_bit(input logic v);
        ps2_data = v;
        #50;
        ps2_clk = 1'b0;
        #100;
        ps2_clk = 1'b1;
        #50;
    endtask

    task automatic send_frame(input logic [7:0] b, input bit bad_par);
        logic p;
        p = ~(^b);
        if (bad_par) p = ~p;
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) send_bit(b[i]);
        send_bit(p);
        send_bit(1'b1);
        ps2_data = 1'b1;
        #300;
    endtask

    task automatic send_make(input logic [7:0] b);
        send_frame(b, 1'b0);
        exp_ev++;
    endtask

    task automatic send_break(input logic [7:0] b);
        send_frame(8'hF0, 1'b0);
        send_frame(b, 1'b0);
        exp_ev++;
    endtask

    initial begin
        #100;
        async_rst = 1'b0;
        #100;
        check("reset_key_valid", 32'(key_valid), 32'h0);
        check("reset_key_code", key_code, 32'h0);
        check("reset_event_pulses", {29'd0, event_valid, overflow, frame_err}, 32'h0);
        check("reset_event_fields", {22'd0, event_code, event_break, event_ext}, 32'h0);

        // make then break of 1C
        send_make(8'h1C);
        check("make1c_events", ev_count, exp_ev);
        check("make1c_last", {23'd0, last_code, last_break}, {23'd0, 8'h1C, 1'b0});
        check("make1c_valid", 32'(key_valid), 32'h1);
        check("make1c_slot0", 32'(key_code[7:0]), 32'h1C);
        send_break(8'h1C);
        check("brk1c_last", {22'd0, last_code, last_break, last_ext}, {22'd0, 8'h1C, 1'b1, 1'b0});
        check("brk1c_valid", 32'(key_valid), 32'h0);

        // fill table, then overflow
        send_make(8'h1C);
        send_make(8'h1B);
        send_make(8'h23);
        send_make(8'h2B);
        check("fill_valid", 32'(key_valid), 32'hF);
        check("fill_codes", key_code, 32'h2B231B1C);
        send_make(8'h34);
        check("ovf_count", ov_count, 1);
        check("ovf_event", {24'd0, last_code}, 32'h34);
        check("ovf_codes", key_code, 32'h2B231B1C);
        send_break(8'h1B);
        check("free1_valid", 32'(key_valid), 32'hD);
        send_make(8'h34);
        check("refill_valid", 32'(key_valid), 32'hF);
        check("refill_codes", key_code, 32'h2B23341C);
        check("refill_ovf", ov_count, 1);
        check("events_so_far", ev_count, exp_ev);
        send_break(8'h1C);
        send_break(8'h34);
        send_break(8'h23);
        send_break(8'h2B);
        check("clear_valid", 32'(key_valid), 32'h0);

        // extended vs plain 75
        send_frame(8'hE0, 1'b0);
        send_make(8'h75);
        check("ext75_last", {31'd0, last_ext}, 32'h1);
        send_make(8'h75);
        check("two75_valid", 32'(key_valid), 32'h3);
        check("two75_ext", 32'(key_ext[1:0]), 32'h1);
        check("two75_codes", 32'(key_code[15:0]), 32'h7575);
        check("two75_last_ext", {31'd0, last_ext}, 32'h0);
        send_frame(8'hE0, 1'b0);
        send_break(8'h75);
        check("brkext75_valid", 32'(key_valid), 32'h2);
        check("brkext75_last", {30'd0, last_break, last_ext}, 32'h3);

        // bad parity on 1C
        send_frame(8'h1C, 1'b1);
`ifdef PS2_PARITY_CHECK_EN
        exp_err++;
        check("badpar_valid", 32'(key_valid), 32'h2);
`else
        exp_ev++;
        check("badpar_valid", 32'(key_valid), 32'h3);
        check("badpar_slot0", 32'({key_ext[0], key_code[7:0]}), 32'h01C);
`endif
        check("badpar_events", ev_count, exp_ev);
        check("badpar_errs", err_count, exp_err);
        send_break(8'h75);
        send_break(8'h1C);
        check("clear2_valid", 32'(key_valid), 32'h0);

        // timeout after 4 data bits
        send_bit(1'b0);
        for (int i = 0; i < 4; i++) send_bit(1'b1);
        #4000;
        exp_err++;
        check("timeout_errs", err_count, exp_err);
        check("timeout_events", ev_count, exp_ev);
        send_make(8'h1C);
        check("post_to_events", ev_count, exp_ev);
        check("post_to_last", {23'd0, last_code, last_break}, {23'd0, 8'h1C, 1'b0});
        check("post_to_valid", 32'(key_valid), 32'h1);

        // reset mid-frame after F0
        send_frame(8'hF0, 1'b0);
        send_bit(1'b0);
        for (int i = 0; i < 3; i++) send_bit(1'b1);
        async_rst = 1'b1;
        #100;
        ps2_clk  = 1'b1;
        ps2_data = 1'b1;
        #50;
        async_rst = 1'b0;
        #100;
        check("rst_key_valid", 32'(key_valid), 32'h0);
        check("rst_key_code", key_code, 32'h0);
        check("rst_key_ext", 32'(key_ext), 32'h0);
        check("rst_event_fields", {22'd0, event_code, event_break, event_ext}, 32'h0);
        check("rst_pulses", {29'd0, event_valid, overflow, frame_err}, 32'h0);
        check("rst_events", ev_count, exp_ev);
        send_make(8'h1C);
        check("after_rst_last", {22'd0, last_code, last_break, last_ext}, {22'd0, 8'h1C, 1'b0, 1'b0});
        check("after_rst_valid", 32'(key_valid), 32'h1);
        check("final_events", ev_count, exp_ev);
        check("final_errs", err_count, exp_err);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/ps2_nkro_receiver.md
# ps2_nkro_receiver

Parametrised PS/2 keyboard receiver with N-key rollover. It deserialises PS/2 device-to-host frames and decodes make, break and E0-extended scan codes. It maintains a table of up to MAX_KEYS simultaneously held keys and emits a one-cycle event for every completed code. It sits between the PS/2 pins and the note/voice logic, so several notes can sound at once.

## Interface
Parameters:
- MAX_KEYS, 4: number of key-table slots (1–16).
- TIMEOUT_CYCLES, 100000: sys_clk cycles without a ps2_clk falling edge before a partial frame is abandoned (2 ms at 50 MHz).

Ports:
- sys_clk  input  1  system clock; the only clock.
- async_rst  input  1  reset, asynchronous and active-high; clears all state.
- ps2_clk  input  1  raw PS/2 clock pin, asynchronous to sys_clk.
- ps2_data  input  1  raw PS/2 data pin, asynchronous to sys_clk.
- key_code  output  MAX_KEYS*8  flattened table codes; slot i is bits [8i+7:8i].
- key_ext  output  MAX_KEYS  slot i holds an E0-prefixed key.
- key_valid  output  MAX_KEYS  slot i occupied.
- event_valid  output  1  one-cycle pulse: a code completed.
- event_code  output  8  code of that event, held until the next event.
- event_break  output  1  the event was a release.
- event_ext  output  1  the event was E0-prefixed.
- overflow  output  1  one-cycle pulse: make dropped because the table was full.
- frame_err  output  1  one-cycle pulse: start, stop, parity or timeout error.

## Operation
- ps2_clk and ps2_data each pass through a 2-flop synchroniser. One extra ps2_clk flop provides falling-edge detection (fe = prev & ~cur).
- Frame FSM states: IDLE, DATA, PARITY, STOP. All FSM work happens on fe.
  - IDLE: a sampled bit of 0 is the start bit → DATA with bit count 0. A sampled 1 raises frame_err and stays in IDLE.
  - DATA: shift in LSB first. After 8 bits → PARITY.
  - PARITY: capture the bit → STOP.
  - STOP: the bit must be 1, otherwise frame_err. The FSM then returns to IDLE, and a valid byte is passed to the decoder.
- Timeout: a counter is cleared on every fe. If it reaches TIMEOUT_CYCLES outside IDLE, the FSM goes to IDLE and frame_err pulses. When fe and the timeout fall in the same cycle, fe wins.
- Decoder flags: brk and ext.
  - Byte 0xF0 sets brk. Byte 0xE0 sets ext. Neither prefix produces an event.
  - Any other byte produces an event with the current brk and ext, then clears both flags.
  - Any frame_err also clears both flags.
- Key table, updated in the same cycle as the event_valid pulse:
  - Make, where {ext,code} is already present (typematic repeat): table unchanged.
  - Make, not present, free slot available: write to the lowest-index free slot.
  - Make, not present, table full: table unchanged and overflow pulses.
  - Break, matching slot present: clear that slot's key_valid. Code bits are retained and are don't-care.
  - Break, no matching slot: table unchanged. The event still pulses.
- Matching compares all 9 bits {ext,code}. Slots are not compacted.

## Timing
- Reset values: key_code, key_ext, key_valid, event_code, event_break, event_ext are all 0. event_valid, overflow and frame_err are 0. FSM in IDLE, both decoder flags cleared, timeout counter 0.
- Reset asserted mid-frame aborts the frame immediately. No event is produced.
- Pin edge to fe: 3 sys_clk cycles.
- event_valid, event_*, overflow and table outputs all change on the sys_clk edge after the fe that samples the stop bit.
- frame_err for a bad start or stop bit is likewise registered one cycle after that fe.
- All pulses are exactly 1 cycle wide.
- No back-pressure: the consumer must accept event_valid unconditionally.
- Minimum sys_clk is 8× the PS/2 clock.

## Configuration
- Macro: PS2_PARITY_CHECK_EN.
- Defined: odd parity is checked over data plus parity bit. On mismatch the byte is discarded, frame_err pulses and the decoder flags clear.
- Undefined: the parity bit is sampled and ignored, and parity never raises frame_err.

## Structure
- Package ps2_pkg holds:
  - constants PS2_BREAK = 8'hF0 and PS2_EXT = 8'hE0;
  - the frame-state enum;
  - a packed key_entry_t {ext, code}.
- Sub-module ps2_frame_rx contains the synchronisers, edge detect, frame FSM, timeout and parity. It outputs byte_valid, byte and frame_err.
- The top level contains the decoder and the key table.

## Test plan
- Frames 0x1C, then F0 1C → make event (code 1C, break 0), slot 0 valid with 0x1C. Then a break event, and key_valid = 0.
- With MAX_KEYS=4, makes 1C 1B 23 2B 34 → slots 0–3 filled, fifth event raises overflow, table unchanged. Then F0 1B → slot 1 freed. Then make 34 → lands in slot 1.
- E0 75, then 75 → two slots, {1,75} and {0,75}. Then E0 F0 75 → only the ext slot is cleared.
- Bad parity on 0x1C with the macro defined → frame_err, no event. Same frame with the macro undefined → event 1C.
- Hold ps2_clk high after 4 data bits for TIMEOUT_CYCLES → frame_err, FSM back in IDLE. The next clean 0x1C frame decodes correctly.
- Assert async_rst mid-frame after an F0 → all outputs 0. The next 0x1C is decoded as a make, not a break.
